// File: rtl/fpu_share_arbiter_if.sv
// rtl/fpu_share_arbiter_if.sv - requester and FPU issue/return bundle for fpu_share_arbiter
// slave is the arbiter's view; master is the requester/FPU side.
interface fpu_share_arbiter_if #(
   parameter int N   = 4,
   parameter int NX  = 8,
   parameter int NM  = 23,
   parameter int OPW = 3
);
   localparam int W = 1 + NX + NM;

   logic [N-1:0]     req_valid;
   logic [N-1:0]     req_ready;
   logic [N*OPW-1:0] req_op;
   logic [N*W-1:0]   req_a;
   logic [N*W-1:0]   req_b;
   logic [N-1:0]     rsp_valid;
   logic [W-1:0]     rsp_res;
   logic             fpu_in_valid;
   logic [OPW-1:0]   fpu_op;
   logic [W-1:0]     fpu_a;
   logic [W-1:0]     fpu_b;
   logic             fpu_out_valid;
   logic [W-1:0]     fpu_res;

   modport slave (
      input  req_valid, req_op, req_a, req_b, fpu_out_valid, fpu_res,
      output req_ready, rsp_valid, rsp_res, fpu_in_valid, fpu_op, fpu_a, fpu_b
   );

   modport master (
      output req_valid, req_op, req_a, req_b, fpu_out_valid, fpu_res,
      input  req_ready, rsp_valid, rsp_res, fpu_in_valid, fpu_op, fpu_a, fpu_b
   );
endinterface

// File: rtl/fpu_share_arbiter.sv
// rtl/fpu_share_arbiter.sv - round-robin sharing of one pipelined FPU among N requesters
// Optional FPU_ARB_STATS_EN adds stat_issued/stat_stall counters.
module fpu_share_arbiter #(
   parameter int N       = 4,
   parameter int NX      = 8,
   parameter int NM      = 23,
   parameter int OPW     = 3,
   parameter int LAT     = 4,
   parameter int MAX_OUT = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   fpu_share_arbiter_if.slave bus,
   input  logic               drain_req,
   output logic               drain_done,
   output logic               err
`ifdef FPU_ARB_STATS_EN
   ,
   output logic [31:0]        stat_issued,
   output logic [31:0]        stat_stall
`endif
);
   localparam int W   = 1 + NX + NM;
   localparam int IDW = $clog2(N);
   localparam int CW  = $clog2(MAX_OUT + 1);

   typedef enum logic [1:0] {RUN, DRAIN, IDLE} state_t;

   state_t           state, state_nxt;
   logic [IDW-1:0]   ptr;
   logic [CW-1:0]    cnt [N];
   logic [N-1:0]     eligible;
   logic [N-1:0]     grant;
   logic [IDW-1:0]   gid;
   logic             found;
   logic [IDW-1:0]   iss_id;
   logic [LAT-1:0]   tag_v;
   logic [IDW-1:0]   tag_id [LAT];
   logic             rsp_hit;
   logic             pipe_empty;

   // rst_n gates eligibility so req_ready is already low while reset is held
   always_comb begin
      eligible = '0;
      for (int i = 0; i < N; i++) begin
         eligible[i] = rst_n && (state == RUN) && !drain_req && bus.req_valid[i]
                       && (cnt[i] < CW'(MAX_OUT));
      end
   end

   always_comb begin
      found = 1'b0;
      gid   = '0;
      for (int k = 1; k <= N; k++) begin
         if (!found && eligible[(int'(ptr) + k) % N]) begin
            found = 1'b1;
            gid   = IDW'((int'(ptr) + k) % N);
         end
      end
      grant = found ? (N'(1) << gid) : '0;
   end

   assign bus.req_ready = grant;
   assign rsp_hit       = bus.fpu_out_valid && tag_v[LAT-1];
   assign pipe_empty    = !(|tag_v) && !bus.fpu_in_valid;
   assign drain_done    = (state == IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.fpu_in_valid <= 1'b0;
         bus.fpu_op       <= '0;
         bus.fpu_a        <= '0;
         bus.fpu_b        <= '0;
         iss_id           <= '0;
         ptr              <= IDW'(N - 1);
      end else begin
         bus.fpu_in_valid <= found;
         if (found) begin
            bus.fpu_op <= bus.req_op[int'(gid)*OPW +: OPW];
            bus.fpu_a  <= bus.req_a[int'(gid)*W +: W];
            bus.fpu_b  <= bus.req_b[int'(gid)*W +: W];
            iss_id     <= gid;
            ptr        <= gid;
         end
      end
   end

   // Tag pipe tracks the FPU's fixed latency; its tail lines up with fpu_out_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_v         <= '0;
         bus.rsp_valid <= '0;
         bus.rsp_res   <= '0;
         err           <= 1'b0;
         for (int j = 0; j < LAT; j++) tag_id[j] <= '0;
      end else begin
         tag_v[0]  <= bus.fpu_in_valid;
         tag_id[0] <= iss_id;
         for (int j = 1; j < LAT; j++) begin
            tag_v[j]  <= tag_v[j-1];
            tag_id[j] <= tag_id[j-1];
         end
         bus.rsp_valid <= rsp_hit ? (N'(1) << tag_id[LAT-1]) : '0;
         if (rsp_hit) bus.rsp_res <= bus.fpu_res;
         if (bus.fpu_out_valid != tag_v[LAT-1]) err <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            case ({grant[i], bus.rsp_valid[i]})
               2'b10:   cnt[i] <= cnt[i] + CW'(1);
               2'b01:   cnt[i] <= cnt[i] - CW'(1);
               default: cnt[i] <= cnt[i];
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= RUN;
      else        state <= state_nxt;
   end

   // The response register needs no emptiness test: it only refills from the tag pipe.
   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (drain_req) state_nxt = DRAIN;
         DRAIN:   if (!drain_req) state_nxt = RUN;
                  else if (pipe_empty) state_nxt = IDLE;
         IDLE:    if (!drain_req) state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

`ifdef FPU_ARB_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_issued <= '0;
         stat_stall  <= '0;
      end else if (state != IDLE) begin
         if (bus.fpu_in_valid) stat_issued <= stat_issued + 32'd1;
         if ((|bus.req_valid) && !found) stat_stall <= stat_stall + 32'd1;
      end
   end
`else
   // statistics counters are not built in this configuration
`endif
endmodule

// File: tb/tb_fpu_share_arbiter.sv
// tb/tb_fpu_share_arbiter.sv - randomized bench for fpu_share_arbiter with a queue-based reference model
module tb_fpu_share_arbiter;
   localparam int N = 4, NX = 8, NM = 23, OPW = 3, LAT = 3, MAX_OUT = 2;
   localparam int W = 1 + NX + NM;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic drain_req = 1'b0;
   logic drain_done, err;
`ifdef FPU_ARB_STATS_EN
   logic [31:0] stat_issued, stat_stall;
`endif

   always #5 clk = ~clk;

   fpu_share_arbiter_if #(.N(N), .NX(NX), .NM(NM), .OPW(OPW)) bus ();

   fpu_share_arbiter #(.N(N), .NX(NX), .NM(NM), .OPW(OPW), .LAT(LAT), .MAX_OUT(MAX_OUT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .drain_req  (drain_req),
      .drain_done (drain_done),
`ifdef FPU_ARB_STATS_EN
      .stat_issued(stat_issued),
      .stat_stall (stat_stall),
`endif
      .err        (err)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] fpu_fn(input logic [OPW-1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
      if (op == '0 && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
      return (a + b) ^ {b[15:0], a[15:0]} ^ W'(op);
   endfunction

   // Reference model: outstanding ops as a queue of {due cycle, requester, result}.
   typedef struct {
      int             due;
      int             id;
      logic [W-1:0]   res;
   } pend_t;

   pend_t          pend[$];
   int             cyc;
   int             m_ptr;
   int             m_cnt [N];
   int             m_mode;
   logic           m_err;
   logic           m_iss_v;
   logic [OPW-1:0] m_op;
   logic [W-1:0]   m_a, m_b, m_res;

   logic           dl_v [LAT];
   logic [W-1:0]   dl_r [LAT];

   task automatic model_clear();
      pend.delete();
      m_ptr   = N - 1;
      m_mode  = 0;
      m_err   = 1'b0;
      m_iss_v = 1'b0;
      m_op    = '0;
      m_a     = '0;
      m_b     = '0;
      m_res   = '0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
   endtask

   task automatic model_cycle();
      logic [N-1:0] exp_rdy;
      logic [N-1:0] exp_rv;
      logic         due_next;
      int           g;
      exp_rdy = '0;
      exp_rv  = '0;
      g       = -1;
      if (m_mode == 0 && !drain_req) begin
         for (int k = 1; k <= N; k++) begin
            if (g < 0 && bus.req_valid[(m_ptr + k) % N] && m_cnt[(m_ptr + k) % N] < MAX_OUT)
               g = (m_ptr + k) % N;
         end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("req_ready", bus.req_ready, exp_rdy);
      check("fpu_in_valid", bus.fpu_in_valid, m_iss_v);
      check("fpu_issue", {bus.fpu_op, bus.fpu_a, bus.fpu_b}, {m_op, m_a, m_b});
      if (pend.size() > 0 && pend[0].due == cyc) begin
         exp_rv[pend[0].id] = 1'b1;
         m_res = pend[0].res;
         m_cnt[pend[0].id]--;
         void'(pend.pop_front());
      end
      check("rsp_valid", bus.rsp_valid, exp_rv);
      check("rsp_res", bus.rsp_res, m_res);
      check("drain_done", drain_done, m_mode == 2);
      check("err", err, m_err);
      due_next = (pend.size() > 0 && pend[0].due == cyc + 1);
      if (bus.fpu_out_valid != due_next) m_err = 1'b1;
      m_iss_v = (g >= 0);
      if (g >= 0) begin
         m_cnt[g]++;
         m_ptr = g;
         m_op  = bus.req_op[g*OPW +: OPW];
         m_a   = bus.req_a[g*W +: W];
         m_b   = bus.req_b[g*W +: W];
         pend.push_back('{due: cyc + LAT + 2, id: g, res: fpu_fn(m_op, m_a, m_b)});
      end
      case (m_mode)
         0:       if (drain_req) m_mode = 1;
         1:       if (!drain_req) m_mode = 0; else if (pend.size() == 0) m_mode = 2;
         default: if (!drain_req) m_mode = 0;
      endcase
      cyc++;
   endtask

   // One clock: FPU model and request drive after the edge, checks on the falling edge.
   task automatic step(input logic [N-1:0] v, input logic dr, input logic inj, input logic fixed);
      @(posedge clk);
      #1;
      bus.fpu_out_valid = dl_v[LAT-1] | inj;
      bus.fpu_res       = dl_v[LAT-1] ? dl_r[LAT-1] : W'($urandom);
      for (int j = LAT - 1; j > 0; j--) begin
         dl_v[j] = dl_v[j-1];
         dl_r[j] = dl_r[j-1];
      end
      dl_v[0] = bus.fpu_in_valid;
      dl_r[0] = fpu_fn(bus.fpu_op, bus.fpu_a, bus.fpu_b);
      bus.req_valid = v;
      drain_req     = dr;
      for (int i = 0; i < N; i++) begin
         bus.req_op[i*OPW +: OPW] = OPW'($urandom);
         bus.req_a[i*W +: W]      = $urandom;
         bus.req_b[i*W +: W]      = $urandom;
      end
      if (fixed) begin
         bus.req_op[OPW-1:0] = '0;
         bus.req_a[W-1:0]    = 32'h3F80_0000;
         bus.req_b[W-1:0]    = 32'h4000_0000;
      end
      @(negedge clk);
      model_cycle();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_req_ready", bus.req_ready, '0);
      check("rst_rsp_valid", bus.rsp_valid, '0);
      check("rst_rsp_res", bus.rsp_res, '0);
      check("rst_fpu_in_valid", bus.fpu_in_valid, '0);
      check("rst_fpu_issue", {bus.fpu_op, bus.fpu_a, bus.fpu_b}, '0);
      check("rst_drain_done", drain_done, '0);
      check("rst_err", err, '0);
      bus.req_valid     = '0;
      bus.fpu_out_valid = 1'b0;
      drain_req         = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   int lat, acc, rsp_at, reacc, last_rsp, done_at, nrsp, drain_left;
   int grants[$];

   initial begin
      bus.req_valid     = '0;
      bus.req_op        = '0;
      bus.req_a         = '0;
      bus.req_b         = '0;
      bus.fpu_out_valid = 1'b0;
      bus.fpu_res       = '0;
      for (int j = 0; j < LAT; j++) begin
         dl_v[j] = 1'b0;
         dl_r[j] = '0;
      end
      cyc = 0;
      @(negedge clk);
      do_reset();

      // single operation: response five cycles after accept
      step(4'b0001, 1'b0, 1'b0, 1'b1);
      check("single_ready", bus.req_ready, 4'b0001);
      lat = -1;
      for (int i = 1; i <= 8; i++) begin
         step(4'b0000, 1'b0, 1'b0, 1'b0);
         if (bus.rsp_valid == 4'b0001 && lat < 0) begin
            lat = i;
            check("single_res", bus.rsp_res, 32'h4040_0000);
         end
      end
      check("single_latency", lat, 5);

      // round robin with all requesters valid
      do_reset();
      grants.delete();
      for (int i = 0; i < 8; i++) begin
         step(4'b1111, 1'b0, 1'b0, 1'b0);
         for (int k = 0; k < N; k++) if (bus.req_ready[k]) grants.push_back(k);
      end
      check("rr_grant_count", grants.size(), 8);
      for (int i = 0; i < grants.size(); i++) check("rr_order", grants[i], i % N);
      for (int i = 0; i < 10; i++) step(4'b0000, 1'b0, 1'b0, 1'b0);

      // credit limit on a lone requester
      do_reset();
      acc = 0; rsp_at = -1; reacc = -1;
      for (int i = 0; i < 10; i++) begin
         step(4'b0100, 1'b0, 1'b0, 1'b0);
         if (bus.req_ready[2]) begin
            if (i < 6) acc++;
            if (i >= 2 && reacc < 0) reacc = i;
         end
         if (bus.rsp_valid[2] && rsp_at < 0) rsp_at = i;
      end
      check("credit_accepts", acc, 2);
      check("credit_first_rsp", rsp_at, 5);
      check("credit_reaccept", reacc, 6);
      for (int i = 0; i < 8; i++) step(4'b0000, 1'b0, 1'b0, 1'b0);

      // drain with three ops in flight
      do_reset();
      for (int i = 0; i < 3; i++) step(4'b0111, 1'b0, 1'b0, 1'b0);
      last_rsp = -1; done_at = -1; nrsp = 0;
      for (int i = 0; i < 12; i++) begin
         step(4'b1111, 1'b1, 1'b0, 1'b0);
         if (|bus.rsp_valid) last_rsp = i;
         nrsp += $countones(bus.rsp_valid);
         if (drain_done && done_at < 0) done_at = i;
      end
      check("drain_rsp_count", nrsp, 3);
      check("drain_last_rsp", last_rsp, 4);
      check("drain_done_at", done_at, 5);
      step(4'b1111, 1'b0, 1'b0, 1'b0);
      step(4'b1111, 1'b0, 1'b0, 1'b0);
      check("drain_resume", |bus.req_ready, 1'b1);
      for (int i = 0; i < 10; i++) step(4'b0000, 1'b0, 1'b0, 1'b0);

      // randomized traffic with occasional drain bursts
      do_reset();
      drain_left = 0;
      for (int i = 0; i < 600; i++) begin
         if (drain_left == 0 && $urandom_range(0, 39) == 0) drain_left = $urandom_range(2, 15);
         step((i % 3 == 0) ? N'($urandom & $urandom) : N'($urandom), drain_left > 0, 1'b0, 1'b0);
         if (drain_left > 0) drain_left--;
      end
      for (int i = 0; i < 10; i++) step(4'b0000, 1'b0, 1'b0, 1'b0);

      // spurious FPU result sets a sticky error
      step(4'b0000, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step(4'b0000, 1'b0, 1'b0, 1'b0);
      check("err_sticky", err, 1'b1);

      // reset mid-flight: stale FPU results afterwards must raise err again
      for (int i = 0; i < 3; i++) step(4'b1111, 1'b0, 1'b0, 1'b0);
      do_reset();
      for (int i = 0; i < 30; i++) step(N'($urandom), 1'b0, 1'b0, 1'b0);
      check("err_after_reset", err, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fpu_share_arbiter.md
Name: fpu_share_arbiter

Overview:
- Shares one pipelined IEEE754 floating-point unit between N requesters.
- Arbitrates with a round-robin policy and issues one operation per cycle to the FPU through a registered issue stage.
- Tracks each in-flight operation with a requester tag and routes the FPU result back to the requester that issued it.
- Sits between the per-lane float consumers and the single FPU instance, which uses the `IEEE754(NX, NM)` packed operand layout.

Parameters:
- N, 4, number of requesters (2..16).
- NX, 8, exponent width.
- NM, 23, mantissa width. Operand width W = 1+NX+NM.
- OPW, 3, opcode width.
- LAT, 4, fixed FPU latency in cycles from FPU_IN_VALID to FPU_OUT_VALID (>=1).
- MAX_OUT, 2, maximum outstanding operations per requester (>=1).

Ports:
- CLK  in  1  clock.
- RST_N  in  1  asynchronous active-low reset.
- REQ_VALID  in  N  per-requester operation valid.
- REQ_READY  out  N  per-requester accept.
- REQ_OP  in  N*OPW  packed opcodes; requester i occupies slice i.
- REQ_A  in  N*W  packed operand A.
- REQ_B  in  N*W  packed operand B.
- RSP_VALID  out  N  one-cycle result strobe per requester.
- RSP_RES  out  W  result, shared by all requesters.
- FPU_IN_VALID  out  1  issue strobe to FPU.
- FPU_OP  out  OPW  issued opcode.
- FPU_A  out  W  issued operand A.
- FPU_B  out  W  issued operand B.
- FPU_OUT_VALID  in  1  FPU result strobe.
- FPU_RES  in  W  FPU result.
- DRAIN_REQ  in  1  level request to stop issuing and empty the pipeline.
- DRAIN_DONE  out  1  high while drained.
- ERR  out  1  sticky protocol error.

Behaviour:
- Reset values (async, on RST_N low), all outputs 0:
  - REQ_READY, RSP_VALID, RSP_RES, FPU_IN_VALID, FPU_OP, FPU_A, FPU_B, DRAIN_DONE and ERR are 0.
  - Round-robin pointer = N-1, so requester 0 has first priority.
  - All outstanding counters and tag-pipe entries are cleared.
  - FSM = RUN.
  - A reset mid-operation discards all in-flight tags. FPU results arriving after reset set ERR (no matching tag).
- Eligibility: requester i is eligible when REQ_VALID[i]=1, cnt[i] < MAX_OUT and FSM=RUN.
- Grant:
  - The grant goes to the first eligible requester scanning from ptr+1 upward, wrapping modulo N.
  - REQ_READY is combinational and one-hot (or zero); it is only ever set for the granted requester.
  - Accept = REQ_VALID[i] & REQ_READY[i].
  - ptr updates to i only on accept.
- Issue stage (registered):
  - The cycle after accept: FPU_IN_VALID=1, with FPU_OP/FPU_A/FPU_B = the accepted requester's fields.
  - With no accept, FPU_IN_VALID=0 and the data outputs hold their values.
- Tag pipe:
  - Depth LAT; each entry is {valid, id[clog2(N)-1:0]}.
  - Loaded with {FPU_IN_VALID, issued id}, shifting every cycle.
  - The pipe output aligns with FPU_OUT_VALID.
- Response:
  - The cycle after FPU_OUT_VALID with a valid tag: RSP_VALID[id]=1 and RSP_RES=FPU_RES.
  - Total latency from accept to RSP_VALID = LAT+2 cycles.
  - Results are never stalled; requesters must sink RSP_VALID.
- ERR sets, and stays set until reset, on either:
  - FPU_OUT_VALID=1 with tag invalid, or
  - tag valid with FPU_OUT_VALID=0.
- Counters:
  - cnt[i] increments on accept and decrements on RSP_VALID[i].
  - Both in the same cycle leaves cnt[i] unchanged.
  - Width is clog2(MAX_OUT+1); it never overflows because eligibility gates on cnt[i] < MAX_OUT.
- FSM (RUN, DRAIN, IDLE):
  - RUN -> DRAIN when DRAIN_REQ=1. No grants are made from that cycle onward.
  - DRAIN -> IDLE when the tag pipe, issue stage and response register are all empty.
  - IDLE: DRAIN_DONE=1.
  - IDLE -> RUN when DRAIN_REQ=0.
  - DRAIN -> RUN if DRAIN_REQ drops before the pipeline is empty; in-flight operations complete normally.
- Simultaneous events: DRAIN_REQ rising in the same cycle as a candidate grant takes precedence, so no accept occurs.

Optional Feature:
- Macro: FPU_ARB_STATS_EN.
- When defined, two extra output ports are added:
  - STAT_ISSUED [31:0]: counts FPU_IN_VALID cycles.
  - STAT_STALL [31:0]: counts cycles with at least one REQ_VALID bit set and no accept.
- Both counters reset to 0, wrap at 2^32, and freeze while FSM=IDLE.
- When the macro is undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Setup: N=4, LAT=3, MAX_OUT=2 unless stated.
- Single op: REQ_VALID=0001, A=0x3F800000, B=0x40000000 -> REQ_READY=0001 in the same cycle; FPU_IN_VALID plus operands 1 cycle later; model FPU returns 0x40400000 -> RSP_VALID=0001, RSP_RES=0x40400000 exactly 5 cycles after accept.
- Round-robin: REQ_VALID=1111 held for 8 cycles -> grant order 0,1,2,3, then each requester is blocked at cnt=2 until its responses return; RSP_VALID order matches the issue order, with no cross-routing.
- Credit limit: requester 2 alone, valid held -> exactly 2 accepts, REQ_READY[2]=0 until the first RSP_VALID[2], accept the following cycle.
- Drain: DRAIN_REQ=1 with 3 ops in flight -> no new REQ_READY; all 3 responses delivered; DRAIN_DONE=1 the cycle after the last RSP_VALID; DRAIN_REQ=0 -> grants resume the next cycle.
- Error/reset: inject FPU_OUT_VALID with empty pipe -> ERR=1 and stays set; pulse RST_N low mid-flight -> all outputs 0 immediately, counters cleared, ERR cleared.
- With FPU_ARB_STATS_EN: 10 cycles of REQ_VALID=0001 with MAX_OUT=2, LAT=3 -> STAT_ISSUED=4, STAT_STALL=6.
